// File: rtl/s1_pkg.sv
// Shared types and constants for the column buffer.
// S1_COL_STATS_EN enables per-column pop counters.
package s1_pkg;
   typedef logic [1:0] col_data_t;
   localparam int S1_STAT_W = 8;
endpackage

// File: rtl/s1_col_fifo.sv
// One column FIFO: storage, pointers, occupancy count, optional pop counter.
// S1_COL_STATS_EN adds stat_xfer, a saturating count of pops.
module s1_col_fifo
   import s1_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      flush,
   input  logic      in_val,
   input  col_data_t in_data,
   output logic      in_rdy,
   output logic      s1_oval,
   output col_data_t s1_odata,
   input  logic      s1_ordy,
`ifdef S1_COL_STATS_EN
   output logic [S1_STAT_W-1:0] stat_xfer,
`endif
   output logic      empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   col_data_t       mem [DEPTH];
   logic [AW-1:0]   rptr, wptr;
   logic [CW-1:0]   count;
   logic            push, pop;

   // Ready looks only at the stored count, so a full column never accepts
   // a push in the same cycle it pops.
   assign in_rdy   = (count != CW'(DEPTH));
   assign s1_oval  = (count != '0);
   assign empty    = (count == '0);
   assign s1_odata = mem[rptr];
   assign push     = in_val & in_rdy;
   assign pop      = s1_oval & s1_ordy;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         rptr  <= '0;
         wptr  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         count <= '0;
         rptr  <= '0;
         wptr  <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= in_data;
            wptr      <= wptr + AW'(1);
         end
         if (pop) rptr <= rptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

`ifdef S1_COL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || flush)
         stat_xfer <= '0;
      else if (pop && (stat_xfer != '1))
         stat_xfer <= stat_xfer + S1_STAT_W'(1);
   end
`endif
endmodule

// File: rtl/s1_col_buffer.sv
// Array of independent per-column FIFOs feeding the downstream stage.
// S1_COL_STATS_EN exposes per-column pop counters on stat_xfer.
module s1_col_buffer
   import s1_pkg::*;
#(
   parameter int COLS  = 4,
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [COLS-1:0]       in_val,
   input  col_data_t [COLS-1:0]  in_data,
   output logic [COLS-1:0]       in_rdy,
   output logic [COLS-1:0]       s1_oval,
   output col_data_t [COLS-1:0]  s1_odata,
   input  logic [COLS-1:0]       s1_ordy,
`ifdef S1_COL_STATS_EN
   output logic [COLS-1:0][S1_STAT_W-1:0] stat_xfer,
`endif
   output logic                  all_empty
);
   logic [COLS-1:0] col_empty;

   for (genvar g = 0; g < COLS; g++) begin : g_col
      s1_col_fifo #(.DEPTH(DEPTH)) u_col (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .in_val   (in_val[g]),
         .in_data  (in_data[g]),
         .in_rdy   (in_rdy[g]),
         .s1_oval  (s1_oval[g]),
         .s1_odata (s1_odata[g]),
         .s1_ordy  (s1_ordy[g]),
`ifdef S1_COL_STATS_EN
         .stat_xfer(stat_xfer[g]),
`endif
         .empty    (col_empty[g])
      );
   end

   assign all_empty = &col_empty;
endmodule

// File: tb/tb_s1_col_buffer.sv
// Directed vector bench for s1_col_buffer (COLS=4, DEPTH=2).
// Defining S1_COL_STATS_EN also exercises the pop counters.
module tb_s1_col_buffer;
   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            flush = 1'b0;
   logic [3:0]      in_val = '0;
   logic [3:0][1:0] in_data = '0;
   logic [3:0]      in_rdy;
   logic [3:0]      s1_oval;
   logic [3:0][1:0] s1_odata;
   logic [3:0]      s1_ordy = '0;
   logic            all_empty;
`ifdef S1_COL_STATS_EN
   logic [3:0][7:0] stat_xfer;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   s1_col_buffer #(.COLS(4), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_val(in_val), .in_data(in_data), .in_rdy(in_rdy),
      .s1_oval(s1_oval), .s1_odata(s1_odata), .s1_ordy(s1_ordy),
`ifdef S1_COL_STATS_EN
      .stat_xfer(stat_xfer),
`endif
      .all_empty(all_empty)
   );

   typedef struct {
      logic       rst, flush;
      logic [3:0] val;
      logic [7:0] data;
      logic [3:0] ordy;
      logic [3:0] e_rdy, e_oval;
      logic [7:0] e_data;
      logic       e_ae;
      logic       raw;   // compare s1_odata in full, not just valid columns
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic f, input logic [3:0] v,
                      input logic [7:0] d, input logic [3:0] o,
                      input logic [3:0] er, input logic [3:0] eo,
                      input logic [7:0] ed, input logic ea, input logic rw);
      vec_t x;
      x.rst = r; x.flush = f; x.val = v; x.data = d; x.ordy = o;
      x.e_rdy = er; x.e_oval = eo; x.e_data = ed; x.e_ae = ea; x.raw = rw;
      vq.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mask_data(input logic [7:0] d, input logic [3:0] v);
      logic [7:0] m;
      for (int c = 0; c < 4; c++) m[2*c +: 2] = v[c] ? d[2*c +: 2] : 2'b00;
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //  rst flush val    data   ordy    e_rdy   e_oval  e_data e_ae raw
      add(1, 0, 4'h0, 8'h00, 4'h0, 4'hF, 4'h0, 8'h00, 1, 1); // reset
      add(0, 0, 4'h0, 8'h00, 4'h0, 4'hF, 4'h0, 8'h00, 1, 0); // idle
      // col0: fill with 01,10 while stalled, push on full ignored, drain in order
      add(0, 0, 4'h1, 8'h01, 4'h0, 4'hF, 4'h1, 8'h01, 0, 0);
      add(0, 0, 4'h1, 8'h02, 4'h0, 4'hE, 4'h1, 8'h01, 0, 0);
      add(0, 0, 4'h1, 8'h03, 4'h0, 4'hE, 4'h1, 8'h01, 0, 0);
      add(0, 0, 4'h0, 8'h00, 4'h1, 4'hF, 4'h1, 8'h02, 0, 0);
      add(0, 0, 4'h0, 8'h00, 4'h1, 4'hF, 4'h0, 8'h00, 1, 0);
      // col2: count 2 -> 1 (full, no pass-through) -> 2, then drain 11,00,01
      add(0, 0, 4'h4, 8'h30, 4'h0, 4'hF, 4'h4, 8'h30, 0, 0);
      add(0, 0, 4'h4, 8'h00, 4'h0, 4'hB, 4'h4, 8'h30, 0, 0);
      add(0, 0, 4'h4, 8'h10, 4'h4, 4'hF, 4'h4, 8'h00, 0, 0);
      add(0, 0, 4'h4, 8'h10, 4'h0, 4'hB, 4'h4, 8'h00, 0, 0);
      add(0, 0, 4'h0, 8'h00, 4'h4, 4'hF, 4'h4, 8'h10, 0, 0);
      add(0, 0, 4'h0, 8'h00, 4'h4, 4'hF, 4'h0, 8'h00, 1, 0);
      // col1: stream 3,0,1,2,3 with push and pop every cycle
      add(0, 0, 4'h2, 8'h0C, 4'h2, 4'hF, 4'h2, 8'h0C, 0, 0);
      add(0, 0, 4'h2, 8'h00, 4'h2, 4'hF, 4'h2, 8'h00, 0, 0);
      add(0, 0, 4'h2, 8'h04, 4'h2, 4'hF, 4'h2, 8'h04, 0, 0);
      add(0, 0, 4'h2, 8'h08, 4'h2, 4'hF, 4'h2, 8'h08, 0, 0);
      add(0, 0, 4'h2, 8'h0C, 4'h2, 4'hF, 4'h2, 8'h0C, 0, 0);
      add(0, 0, 4'h0, 8'h00, 4'h2, 4'hF, 4'h0, 8'h00, 1, 0);
      // flush with col0/col3 occupied and a concurrent push on col3
      add(0, 0, 4'h9, 8'hC2, 4'h0, 4'hF, 4'h9, 8'hC2, 0, 0);
      add(0, 1, 4'h8, 8'h40, 4'h0, 4'hF, 4'h0, 8'h00, 1, 0);
      add(0, 0, 4'h0, 8'h00, 4'h0, 4'hF, 4'h0, 8'h00, 1, 0);
      // reset mid-transfer wins over flush and clears storage
      add(0, 0, 4'h3, 8'h0B, 4'h0, 4'hF, 4'h3, 8'h0B, 0, 0);
      add(1, 1, 4'h3, 8'h0F, 4'h3, 4'hF, 4'h0, 8'h00, 1, 1);
      add(0, 0, 4'h0, 8'h00, 4'h0, 4'hF, 4'h0, 8'h00, 1, 1);

      foreach (vq[i]) begin
         rst = vq[i].rst; flush = vq[i].flush; in_val = vq[i].val;
         in_data = vq[i].data; s1_ordy = vq[i].ordy;
         step();
         chk($sformatf("v%0d in_rdy", i), 32'(in_rdy), 32'(vq[i].e_rdy));
         chk($sformatf("v%0d s1_oval", i), 32'(s1_oval), 32'(vq[i].e_oval));
         chk($sformatf("v%0d s1_odata", i),
             32'(vq[i].raw ? 8'(s1_odata) : mask_data(8'(s1_odata), s1_oval)),
             32'(vq[i].e_data));
         chk($sformatf("v%0d all_empty", i), 32'(all_empty), 32'(vq[i].e_ae));
      end
      rst = 0; flush = 0; in_val = '0; s1_ordy = '0;

      // in_rdy must not react to s1_ordy before the edge
      in_val = 4'h8; in_data = 8'h80; step();
      in_data = 8'h40; step();
      in_val = '0;
      chk("full col3 in_rdy", 32'(in_rdy), 32'h7);
      step();
      chk("stall hold col3 data", 32'(s1_odata[3]), 32'h2);
      s1_ordy = 4'h8; #1;
      chk("no comb ordy->in_rdy", 32'(in_rdy), 32'h7);
      step();
      chk("col3 second entry", 32'(s1_odata[3]), 32'h1);
      chk("col3 rdy after pop", 32'(in_rdy), 32'hF);
      step();
      chk("col3 drained", 32'(all_empty), 32'h1);
      s1_ordy = '0;

`ifdef S1_COL_STATS_EN
      chk("stat col3 pops", 32'(stat_xfer[3]), 32'd2);
      rst = 1; step(); rst = 0;
      chk("stat reset", 32'(stat_xfer), 32'h0);
      in_val = 4'h1; in_data = '0; s1_ordy = 4'h1;
      repeat (11) step();
      chk("stat col0 10 pops", 32'(stat_xfer[0]), 32'd10);
      repeat (290) step();
      in_val = '0;
      step();
      s1_ordy = '0;
      chk("stat col0 saturate", 32'(stat_xfer[0]), 32'd255);
      chk("stat other cols", 32'(stat_xfer[3:1]), 32'h0);
      flush = 1; step(); flush = 0;
      chk("stat flush clear", 32'(stat_xfer[0]), 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/s1_col_buffer.md
S1_COL_BUFFER -- requirements
Module: s1_col_buffer

Interface
REQ-001 Parameter COLS, default 4: number of independent columns.
REQ-002 Parameter DEPTH, default 2: entries per column buffer; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush  input  1  synchronous clear of all column buffers.
REQ-006 in_val  input  [COLS-1:0]  per-column upstream valid.
REQ-007 in_data  input  [COLS-1:0][1:0]  per-column upstream data.
REQ-008 in_rdy  output  [COLS-1:0]  per-column upstream ready.
REQ-009 s1_oval  output  [COLS-1:0]  per-column valid to the downstream stage.
REQ-010 s1_odata  output  [COLS-1:0][1:0]  per-column data to the downstream stage.
REQ-011 s1_ordy  input  [COLS-1:0]  per-column downstream ready.
REQ-012 all_empty  output  1  high when every column buffer holds zero entries.

Function
REQ-013 Each column SHALL be an independent FIFO of DEPTH entries with its own count, read pointer and write pointer.
REQ-014 A push SHALL occur on a column when in_val and in_rdy are both high at a clock edge.
REQ-015 A pop SHALL occur on a column when s1_oval and s1_ordy are both high at a clock edge.
REQ-016 in_rdy[c] SHALL equal (count[c] != DEPTH) and SHALL depend only on registered state, with no combinational path from s1_ordy.
REQ-017 s1_oval[c] SHALL equal (count[c] != 0).
REQ-018 s1_odata[c] SHALL be driven from the head storage entry, with no combinational path from in_data.
REQ-019 Latency SHALL be 1 cycle: data pushed at edge N is presented on s1_odata at edge N+1 if the column was empty.
REQ-020 The FIFO SHALL NOT pass data through while full, so a full column accepts no push even when a pop occurs in the same cycle.
REQ-021 Simultaneous push and pop on a non-empty, non-full column SHALL leave the count unchanged.
REQ-022 Pointers SHALL wrap modulo DEPTH.
REQ-023 s1_odata[c] SHALL be held stable while s1_oval[c] is high and s1_ordy[c] is low.
REQ-024 When flush is high at an edge, every count and pointer SHALL be zeroed, and any push or pop in that same cycle SHALL be discarded.
REQ-025 all_empty SHALL be the AND over all columns of (count == 0).

Reset
REQ-026 While rst is high at an edge, all counts, pointers and storage SHALL clear to 0.
REQ-027 From the cycle after a reset edge: s1_oval = 0, s1_odata = 0, all_empty = 1, in_rdy = all ones.
REQ-028 rst SHALL take priority over flush.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered entries without emitting them.

Configuration
REQ-030 Macro S1_COL_STATS_EN, when defined, SHALL add output stat_xfer [COLS-1:0][7:0].
REQ-031 stat_xfer[c] SHALL count pops on column c, saturating at 255, and SHALL be cleared by rst or flush.
REQ-032 When S1_COL_STATS_EN is undefined, the port and its counters SHALL be absent, with all other behaviour identical.

Structure
REQ-033 Package s1_pkg SHALL hold typedef col_data_t (logic [1:0]) and constant S1_STAT_W = 8.
REQ-034 Sub-module s1_col_fifo SHALL implement one column (storage, pointers, count, optional stat counter); the top level SHALL instantiate it COLS times and form all_empty.

Verification
REQ-035 Reset, then idle: in_rdy = 4'b1111, s1_oval = 0, all_empty = 1.
REQ-036 Column 0: push 2'b01 then 2'b10 with s1_ordy[0] = 0 -> in_rdy[0] = 0 after the 2nd edge; releasing s1_ordy pops 01 then 10 in order.
REQ-037 Column 2 held full while s1_ordy[2] = 1 and in_val[2] = 1 -> no push in the pop cycle; count goes 2, 1, 2 across three edges, with no overflow or loss.
REQ-038 Data 3,0,1,2,3 pushed and popped continuously on column 1 -> output sequence identical; pointers wrap with no duplication.
REQ-039 Flush asserted with columns 0 and 3 holding one entry each and a concurrent push on column 3 -> next cycle all_empty = 1 and s1_oval = 0.
REQ-040 With S1_COL_STATS_EN defined, 300 pops on column 0 -> stat_xfer[0] = 255 and all other columns read 0.
